pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RV32I pipeline. It merges load-use detection, taken-branch squash, data-memory wait and halt (ECALL/EBREAK) drain into one prioritised set of stage enables and flushes. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their enable/flush pins. It also keeps a saturating stall-cycle counter and a memory-timeout fault.

---
 rtl/pipeline_ctrl_pkg.sv | 18 +
 rtl/pipeline_ctrl_if.sv | 43 ++++
 rtl/pipeline_ctrl_load_use.sv | 24 ++
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    // Sequencer states, kept as plain vectors so older tooling can read them
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Register x0 is hard-wired to zero, so a load targeting it never creates a hazard
    localparam logic [4:0] REG_X0 = 5'd0;

    // Default drain length: halting instruction still has to pass EX, MEM and WB
    localparam int DEF_DRAIN_CYCLES = 3;

    // Default limit on consecutive data-memory wait cycles before declaring a fault
    localparam int DEF_MEM_TIMEOUT = 16;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-control outputs shared by the sequencer and the datapath.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       RD_EX;
    logic             isLoad_EX;
    logic [4:0]       RA_ID;
    logic [4:0]       RB_ID;
    logic             useRA_ID;
    logic             useRB_ID;
    logic             branch_taken_EX;
    logic             halt_ID;
    logic             dmem_req_MEM;
    logic             dmem_ready;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_bubble;
    logic             halted;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_count;

    // Sequencer side: observes hazards, drives enables and flushes
    modport master (
        input  RD_EX, isLoad_EX, RA_ID, RB_ID, useRA_ID, useRB_ID,
               branch_taken_EX, halt_ID, dmem_req_MEM, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_bubble, halted, mem_fault, stall_count
    );

    // Datapath side: reports hazards, obeys enables and flushes
    modport slave (
        output RD_EX, isLoad_EX, RA_ID, RB_ID, useRA_ID, useRB_ID,
               branch_taken_EX, halt_ID, dmem_req_MEM, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_bubble, halted, mem_fault, stall_count
    );

endinterface

// File: rtl/pipeline_ctrl_load_use.sv
// Combinational load-use hazard comparator; the stall is visible in the same cycle.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rd_ex,
    input  logic       is_load_ex,
    input  logic [4:0] ra_id,
    input  logic [4:0] rb_id,
    input  logic       use_ra_id,
    input  logic       use_rb_id,
    output logic       load_use
);

    logic hit_ra;
    logic hit_rb;

    // Flag a hazard when the load result is needed by an operand the ID instruction actually reads
    always_comb begin
        hit_ra   = use_ra_id && (ra_id == rd_ex);
        hit_rb   = use_rb_id && (rb_id == rd_ex);
        load_use = is_load_ex && (rd_ex != REG_X0) && (hit_ra || hit_rb);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage RV32I pipeline, with halt drain,
// dmem timeout fault and a saturating stall-cycle counter.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int CNT_W        = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.master bus
);

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_nx;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_nx;
    logic [DRAIN_W-1:0] drain_inc;
    logic [CNT_W-1:0]   stall_count;
    logic               mem_fault;
    logic               fault_set;
    logic               stall_evt;
    logic               mem_busy;
    logic               load_use;

    load_use_detect u_load_use (
        .rd_ex      (bus.RD_EX),
        .is_load_ex (bus.isLoad_EX),
        .ra_id      (bus.RA_ID),
        .rb_id      (bus.RB_ID),
        .use_ra_id  (bus.useRA_ID),
        .use_rb_id  (bus.useRB_ID),
        .load_use   (load_use)
    );

    assign mem_busy  = bus.dmem_req_MEM && !bus.dmem_ready;
    assign drain_inc = drain_cnt + 1'b1;

    // Pick the winning action for this cycle and derive stage controls and next state
    always_comb begin
        bus.pc_en        = 1'b1;
        bus.ifid_en      = 1'b1;
        bus.ifid_flush   = 1'b0;
        bus.idex_en      = 1'b1;
        bus.idex_flush   = 1'b0;
        bus.exmem_en     = 1'b1;
        bus.memwb_bubble = 1'b0;
        bus.halted       = 1'b0;
        state_nx         = state;
        wait_nx          = wait_cnt;
        drain_nx         = drain_cnt;
        fault_set        = 1'b0;
        stall_evt        = 1'b0;

        if (state == ST_RUN || state == ST_DRAIN) begin
            if (mem_busy) begin
                bus.pc_en        = 1'b0;
                bus.ifid_en      = 1'b0;
                bus.idex_en      = 1'b0;
                bus.exmem_en     = 1'b0;
                bus.memwb_bubble = 1'b1;
                stall_evt        = 1'b1;
                if (wait_cnt == WAIT_LIMIT) begin
                    fault_set = 1'b1;
                    state_nx  = ST_HALTED;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end else begin
                wait_nx = '0;
                if (state == ST_DRAIN) begin
                    bus.pc_en      = 1'b0;
                    bus.ifid_flush = 1'b1;
                    drain_nx       = drain_inc;
                    if (drain_inc == DRAIN_LAST) begin
                        state_nx = ST_HALTED;
                    end
                end else if (bus.branch_taken_EX) begin
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end else if (load_use) begin
                    bus.pc_en      = 1'b0;
                    bus.ifid_en    = 1'b0;
                    bus.idex_flush = 1'b1;
                    stall_evt      = 1'b1;
                end else if (bus.halt_ID) begin
                    bus.pc_en      = 1'b0;
                    bus.ifid_flush = 1'b1;
                    state_nx       = ST_DRAIN;
                    drain_nx       = '0;
                end
            end
        end else begin
            bus.pc_en        = 1'b0;
            bus.ifid_en      = 1'b0;
            bus.idex_en      = 1'b0;
            bus.exmem_en     = 1'b0;
            bus.memwb_bubble = 1'b1;
            bus.halted       = 1'b1;
        end
    end

    // Register state, wait/drain counters, sticky fault and the saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            drain_cnt   <= '0;
            stall_count <= '0;
            mem_fault   <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            drain_cnt <= drain_nx;
            if (fault_set) begin
                mem_fault <= 1'b1;
            end
            if (stall_evt && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    assign bus.mem_fault   = mem_fault;
    assign bus.stall_count = stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus a random phase,
// with a second instance using a 3-bit counter to exercise saturation.
module tb_pipeline_ctrl;

    localparam int MT = 16;
    localparam int DC = 3;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rd_ex;
        logic       is_load;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       use_ra;
        logic       use_rb;
        logic       br;
        logic       halt;
        logic       req;
        logic       ready;
    } stim_t;

    typedef struct {
        logic [7:0]  ctrl;
        logic        fault;
        logic [31:0] stall;
        logic [2:0]  stall_sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb_q[$];

    int          m_state;
    int          m_wait;
    int          m_drain;
    logic        m_fault;
    logic [31:0] m_stall;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();
    pipeline_ctrl_if #(.CNT_W(3))  bus_sat ();

    pipeline_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipeline_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT), .CNT_W(3)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat)
    );

    assign bus_sat.RD_EX           = bus.RD_EX;
    assign bus_sat.isLoad_EX       = bus.isLoad_EX;
    assign bus_sat.RA_ID           = bus.RA_ID;
    assign bus_sat.RB_ID           = bus.RB_ID;
    assign bus_sat.useRA_ID        = bus.useRA_ID;
    assign bus_sat.useRB_ID        = bus.useRB_ID;
    assign bus_sat.branch_taken_EX = bus.branch_taken_EX;
    assign bus_sat.halt_ID         = bus.halt_ID;
    assign bus_sat.dmem_req_MEM    = bus.dmem_req_MEM;
    assign bus_sat.dmem_ready      = bus.dmem_ready;

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic modelReset();
        m_state = 0;
        m_wait  = 0;
        m_drain = 0;
        m_fault = 1'b0;
        m_stall = '0;
    endtask

    // Drive one cycle of stimulus, predict outputs, compare mid-cycle, then advance the model
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        exp_t got;
        logic busy;
        logic lu;

        rst_n               = s.rst_n;
        bus.RD_EX           = s.rd_ex;
        bus.isLoad_EX       = s.is_load;
        bus.RA_ID           = s.ra;
        bus.RB_ID           = s.rb;
        bus.useRA_ID        = s.use_ra;
        bus.useRB_ID        = s.use_rb;
        bus.branch_taken_EX = s.br;
        bus.halt_ID         = s.halt;
        bus.dmem_req_MEM    = s.req;
        bus.dmem_ready      = s.ready;

        busy = s.req && !s.ready;
        lu   = s.is_load && (s.rd_ex != 5'd0) &&
               ((s.use_ra && s.ra == s.rd_ex) || (s.use_rb && s.rb == s.rd_ex));

        // bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_bubble halted
        if (m_state == 2)       e.ctrl = 8'b0000_0011;
        else if (busy)          e.ctrl = 8'b0000_0010;
        else if (m_state == 1)  e.ctrl = 8'b0111_0100;
        else if (s.br)          e.ctrl = 8'b1111_1100;
        else if (lu)            e.ctrl = 8'b0001_1100;
        else if (s.halt)        e.ctrl = 8'b0111_0100;
        else                    e.ctrl = 8'b1101_0100;
        e.fault     = m_fault;
        e.stall     = m_stall;
        e.stall_sat = (m_stall > 32'd7) ? 3'd7 : m_stall[2:0];
        sb_q.push_back(e);

        @(negedge clk);
        got = sb_q.pop_front();
        checkOutput("ctrl", {56'd0, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                             bus.idex_flush, bus.exmem_en, bus.memwb_bubble, bus.halted},
                    {56'd0, got.ctrl});
        checkOutput("mem_fault", {63'd0, bus.mem_fault}, {63'd0, got.fault});
        checkOutput("stall_count", {32'd0, bus.stall_count}, {32'd0, got.stall});
        checkOutput("stall_sat", {61'd0, bus_sat.stall_count}, {61'd0, got.stall_sat});

        @(posedge clk);
        if (!s.rst_n) begin
            modelReset();
        end else if (m_state != 2) begin
            if (busy) begin
                m_stall = (m_stall == 32'hFFFF_FFFF) ? m_stall : m_stall + 1;
                if (m_wait == MT - 1) begin
                    m_fault = 1'b1;
                    m_state = 2;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
                if (m_state == 1) begin
                    m_drain++;
                    if (m_drain == DC - 1) m_state = 2;
                end else if (!s.br && lu) begin
                    m_stall = m_stall + 1;
                end else if (!s.br && s.halt) begin
                    m_state = 1;
                    m_drain = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        stim_t s;

        bus.RD_EX           = '0;
        bus.isLoad_EX       = 1'b0;
        bus.RA_ID           = '0;
        bus.RB_ID           = '0;
        bus.useRA_ID        = 1'b0;
        bus.useRB_ID        = 1'b0;
        bus.branch_taken_EX = 1'b0;
        bus.halt_ID         = 1'b0;
        bus.dmem_req_MEM    = 1'b0;
        bus.dmem_ready      = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        modelReset();

        s = idle();
        applyStimulus(s);
        checkOutput("reset_stall", {32'd0, bus.stall_count}, 64'd0);
        checkOutput("reset_halted", {63'd0, bus.halted}, 64'd0);

        // Load to x0, then an unused matching operand: neither stalls
        s = idle(); s.is_load = 1'b1; s.rd_ex = 5'd0; s.ra = 5'd0; s.use_ra = 1'b1;
        applyStimulus(s);
        s = idle(); s.is_load = 1'b1; s.rd_ex = 5'd7; s.rb = 5'd7; s.ra = 5'd3;
        applyStimulus(s);
        checkOutput("x0_unused_stall", {32'd0, bus.stall_count}, 64'd0);

        // Genuine load-use on rs1
        s = idle(); s.is_load = 1'b1; s.rd_ex = 5'd5; s.ra = 5'd5; s.use_ra = 1'b1;
        applyStimulus(s);
        checkOutput("load_use_stall", {32'd0, bus.stall_count}, 64'd1);

        // Taken branch squashes the hazard
        s.br = 1'b1;
        applyStimulus(s);
        checkOutput("branch_stall", {32'd0, bus.stall_count}, 64'd1);

        // Three wait cycles then completion
        s = idle(); s.req = 1'b1;
        repeat (3) applyStimulus(s);
        s.ready = 1'b1;
        applyStimulus(s);
        checkOutput("memwait_stall", {32'd0, bus.stall_count}, 64'd4);

        // Halt with a 2-cycle memory wait inside the drain
        s = idle(); s.halt = 1'b1;
        applyStimulus(s);
        s = idle();
        applyStimulus(s);
        s.req = 1'b1;
        repeat (2) applyStimulus(s);
        checkOutput("drain_not_yet", {63'd0, bus.halted}, 64'd0);
        s = idle();
        applyStimulus(s);
        checkOutput("drain_halted", {63'd0, bus.halted}, 64'd1);
        checkOutput("drain_stall", {32'd0, bus.stall_count}, 64'd6);

        // Reset out of HALTED, enter DRAIN, then reset mid-drain
        s = idle(); s.rst_n = 1'b0;
        applyStimulus(s);
        s = idle(); s.halt = 1'b1;
        applyStimulus(s);
        s = idle();
        applyStimulus(s);
        s.rst_n = 1'b0;
        applyStimulus(s);
        checkOutput("mid_drain_rst_halted", {63'd0, bus.halted}, 64'd0);
        checkOutput("mid_drain_rst_stall", {32'd0, bus.stall_count}, 64'd0);

        // Memory timeout: 16 busy cycles fault and halt from the 17th
        s = idle(); s.req = 1'b1;
        repeat (15) applyStimulus(s);
        checkOutput("timeout_early_fault", {63'd0, bus.mem_fault}, 64'd0);
        applyStimulus(s);
        checkOutput("timeout_fault", {63'd0, bus.mem_fault}, 64'd1);
        checkOutput("timeout_halted", {63'd0, bus.halted}, 64'd1);
        checkOutput("timeout_stall", {32'd0, bus.stall_count}, 64'd16);
        applyStimulus(s);

        s = idle(); s.rst_n = 1'b0;
        applyStimulus(s);

        // Random mix with small register indices so hazards are frequent
        for (int i = 0; i < 300; i++) begin
            s.rst_n   = ($urandom_range(0, 39) != 0);
            s.rd_ex   = 5'($urandom_range(0, 3));
            s.is_load = ($urandom_range(0, 1) == 1);
            s.ra      = 5'($urandom_range(0, 3));
            s.rb      = 5'($urandom_range(0, 3));
            s.use_ra  = ($urandom_range(0, 1) == 1);
            s.use_rb  = ($urandom_range(0, 1) == 1);
            s.br      = ($urandom_range(0, 6) == 0);
            s.halt    = ($urandom_range(0, 11) == 0);
            s.req     = ($urandom_range(0, 2) == 0);
            s.ready   = ($urandom_range(0, 1) == 1);
            applyStimulus(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
